// File: rtl/idex_hazard_ctrl.sv
// idex_hazard_ctrl: ID/EX pipeline sequencer for load-use, multiply-stretch and branch-flush control
module idex_hazard_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       id_rs1_addr_i,
    input  logic [4:0]       id_rs2_addr_i,
    input  logic [4:0]       ex_rd_addr_i,
    input  logic             ex_mem_read_i,
    input  logic [3:0]       ex_alu_ctrl_i,
    input  logic             branch_taken_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             idex_hold_o,
    output logic             exmem_bubble_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] stall_cnt_o
);
    typedef enum logic {RUN, MUL} state_t;
    state_t           r_state;
    logic [3:0]       r_mcnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_mul_ex;
    logic             w_load_use;
    logic             w_mul_stall;
    logic             w_lu_stall;
    assign w_mul_ex    = (ex_alu_ctrl_i == 4'hF) && (MUL_LAT > 1);
    assign w_load_use  = ex_mem_read_i && (ex_rd_addr_i != 5'd0) &&
                         ((ex_rd_addr_i == id_rs1_addr_i) || (ex_rd_addr_i == id_rs2_addr_i));
    assign w_mul_stall = (r_state == RUN) ? w_mul_ex : (r_mcnt != 4'd0);
    assign w_lu_stall  = !w_mul_stall && w_load_use;
    assign pc_write_o     = !(w_mul_stall || w_lu_stall);
    assign ifid_write_o   = pc_write_o;
    assign ifid_flush_o   = pc_write_o && branch_taken_i;
    assign idex_bubble_o  = w_lu_stall;
    assign idex_hold_o    = w_mul_stall;
    assign exmem_bubble_o = w_mul_stall;
    assign busy_o         = w_mul_stall;
    assign stall_cnt_o    = r_stall_cnt;
    // mcnt counts remaining stretch cycles after the entry cycle; the release cycle has mcnt==0
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= RUN;
            r_mcnt      <= 4'd0;
            r_stall_cnt <= '0;
        end else begin
            if (r_state == RUN) begin
                if (w_mul_ex) begin
                    r_state <= MUL;
                    r_mcnt  <= 4'(MUL_LAT - 2);
                end
            end else if (r_mcnt != 4'd0) begin
                r_mcnt <= r_mcnt - 4'd1;
            end else begin
                r_state <= RUN;
            end
            if (!pc_write_o && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_idex_hazard_ctrl.sv
// tb_idex_hazard_ctrl: scoreboard bench for idex_hazard_ctrl (MUL_LAT=4 and MUL_LAT=1/narrow counter builds)
module tb_idex_hazard_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
    logic       mr = 1'b0, br = 1'b0;
    logic [3:0] alu = '0;

    logic        a_pc, a_ifw, a_fl, a_bub, a_hold, a_exb, a_busy;
    logic [15:0] a_cnt;
    logic        b_pc, b_ifw, b_fl, b_bub, b_hold, b_exb, b_busy;
    logic [2:0]  b_cnt;

    typedef struct packed {
        logic [6:0]  c4;
        logic [15:0] n4;
        logic [6:0]  c1;
        logic [2:0]  n1;
    } exp_t;
    exp_t sb[$];

    int total = 0;
    int bad   = 0;
    int occ4 = 0, cnt4 = 0, occ1 = 0, cnt1 = 0;

    always #5 clk = ~clk;

    idex_hazard_ctrl #(.MUL_LAT(4), .CNT_W(16)) dut4 (
        .clk_i(clk), .rst_i(rst), .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2),
        .ex_rd_addr_i(rd), .ex_mem_read_i(mr), .ex_alu_ctrl_i(alu), .branch_taken_i(br),
        .pc_write_o(a_pc), .ifid_write_o(a_ifw), .ifid_flush_o(a_fl), .idex_bubble_o(a_bub),
        .idex_hold_o(a_hold), .exmem_bubble_o(a_exb), .busy_o(a_busy), .stall_cnt_o(a_cnt)
    );

    idex_hazard_ctrl #(.MUL_LAT(1), .CNT_W(3)) dut1 (
        .clk_i(clk), .rst_i(rst), .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2),
        .ex_rd_addr_i(rd), .ex_mem_read_i(mr), .ex_alu_ctrl_i(alu), .branch_taken_i(br),
        .pc_write_o(b_pc), .ifid_write_o(b_ifw), .ifid_flush_o(b_fl), .idex_bubble_o(b_bub),
        .idex_hold_o(b_hold), .exmem_bubble_o(b_exb), .busy_o(b_busy), .stall_cnt_o(b_cnt)
    );

    // Output order: {pc_write, ifid_write, ifid_flush, idex_bubble, idex_hold, exmem_bubble, busy}
    function automatic logic [6:0] ctl(input bit mstall, input bit lu, input bit b);
        if (mstall) return 7'b0000111;
        if (lu)     return 7'b0001000;
        return {2'b11, b, 4'b0000};
    endfunction

    // occ = cycles the current multiply still spends in EX; it stalls while more than one remains
    task automatic model(input int lat, input int cw, inout int occ, inout int cnt,
                         output logic [6:0] c, output int cnt_now);
        int o;
        bit lu;
        o  = rst ? 0 : occ;
        if (o == 0 && alu == 4'hF) o = lat;
        lu = mr && rd != 0 && (rd == rs1 || rd == rs2);
        c  = ctl(o > 1, lu, br);
        cnt_now = rst ? 0 : cnt;
        if (rst) begin
            occ = 0;
            cnt = 0;
        end else begin
            occ = (o > 0) ? o - 1 : 0;
            if (!c[6] && cnt < (1 << cw) - 1) cnt++;
        end
    endtask

    task automatic cyc(input logic r, input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                       input logic m, input logic [3:0] a, input logic b);
        exp_t e;
        int n;
        @(posedge clk);
        #1;
        rst = r; rs1 = s1; rs2 = s2; rd = d; mr = m; alu = a; br = b;
        model(4, 16, occ4, cnt4, e.c4, n);
        e.n4 = 16'(n);
        model(1, 3, occ1, cnt1, e.c1, n);
        e.n1 = 3'(n);
        sb.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                total++;
                if ({a_pc, a_ifw, a_fl, a_bub, a_hold, a_exb, a_busy, a_cnt} != {e.c4, e.n4}) begin
                    bad++;
                    $display("FAIL lat4 t=%0t got ctl=%b cnt=%0d want ctl=%b cnt=%0d",
                             $time, {a_pc, a_ifw, a_fl, a_bub, a_hold, a_exb, a_busy}, a_cnt, e.c4, e.n4);
                end
                total++;
                if ({b_pc, b_ifw, b_fl, b_bub, b_hold, b_exb, b_busy, b_cnt} != {e.c1, e.n1}) begin
                    bad++;
                    $display("FAIL lat1 t=%0t got ctl=%b cnt=%0d want ctl=%b cnt=%0d",
                             $time, {b_pc, b_ifw, b_fl, b_bub, b_hold, b_exb, b_busy}, b_cnt, e.c1, e.n1);
                end
            end
        end
    end

    initial begin : stim
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 5, 0, 5, 1, 0, 0);
        cyc(0, 5, 0, 0, 0, 0, 0);
        cyc(0, 3, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0);
        cyc(0, 7, 0, 7, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 5, 5, 5, 1, 4'hF, 1);
        cyc(0, 1, 2, 3, 0, 0, 1);
        cyc(0, 1, 2, 3, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 4'hF, 0);
        cyc(0, 0, 0, 0, 0, 4'hF, 0);
        cyc(0, 0, 0, 0, 0, 4'hF, 0);
        cyc(1, 0, 0, 0, 0, 4'h0, 0);
        cyc(0, 0, 0, 0, 0, 4'h0, 0);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0, 4'hF, 0);
        for (int i = 0; i < 2000; i++)
            cyc($urandom_range(99) == 0, 5'($urandom_range(3)), 5'($urandom_range(3)),
                5'($urandom_range(3)), 1'($urandom_range(1)),
                ($urandom_range(5) == 0) ? 4'hF : 4'($urandom_range(14)),
                $urandom_range(3) == 0);
        repeat (3) @(posedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain got %0d pending want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
